debug_uart_tx: RTL and testbench

Debug character sink that sits directly downstream of the AXI write-detector debugger stage. It consumes the one-cycle `sig` pulse and `ascii` byte that stage produces, buffers the characters in a small FIFO, and serialises them onto a single 8N1 UART line so simulation or FPGA builds can print software debug output. Its `busy` output feeds back to the debugger's `busy` input to signal back-pressure.

---
 rtl/debug_uart_tx_if.sv | 11 +
 rtl/debug_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_debug_uart_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/debug_uart_tx_if.sv
// Character strobe channel between the AXI write-detector debugger and the UART sink.
// master drives sig/ascii; slave returns busy (back-pressure) and sticky overflow.
interface debug_uart_tx_if;
  logic       sig;
  logic [7:0] ascii;
  logic       busy;
  logic       overflow;

  modport master (output sig, output ascii, input busy, input overflow);
  modport slave  (input sig, input ascii, output busy, output overflow);
endinterface

// File: rtl/debug_uart_tx.sv
// Buffers debug characters in a FIFO and shifts them out as 8N1 UART frames; tx falls one cycle after the push,
// busy = FIFO full, strobes while full are dropped (sticky overflow). DEBUG_UART_CRLF_EN expands LF into CR+LF.
module debug_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 res_n,
  debug_uart_tx_if.slave       dbg,
  output logic                 tx,
  output logic                 tx_active
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] DIV_M1_C = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [7:0]      head;
  logic            push;
  logic            pop;
`ifdef DEBUG_UART_CRLF_EN
  logic            pend_q, pend_d;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    head     = mem_q[rd_ptr_q];
`ifdef DEBUG_UART_CRLF_EN
    pend_d   = pend_q;
`endif
    // Push decision uses the registered count only, so a pop in the same cycle never frees a slot early.
    push     = dbg.sig && (count_q < DEPTH_C);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          timer_d = DIV_M1_C;
        end
      end
      START: begin
        if (timer_q == '0) begin
          state_d = DATA;
          idx_d   = 3'd0;
          timer_d = DIV_M1_C;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = DIV_M1_C;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        if (timer_q == '0) begin
`ifdef DEBUG_UART_CRLF_EN
          if (pend_q) begin
            shift_d = 8'h0A;
            pend_d  = 1'b0;
            state_d = START;
            timer_d = DIV_M1_C;
          end else
`endif
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
            timer_d = DIV_M1_C;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase

    if (pop) begin
`ifdef DEBUG_UART_CRLF_EN
      // LF goes out as CR first; the LF itself is replayed from the pending flag, not the FIFO.
      shift_d = (head == 8'h0A) ? 8'h0D : head;
      pend_d  = (head == 8'h0A);
`else
      shift_d = head;
`endif
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = ovf_q | (dbg.sig & ~push);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = dbg.ascii;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef DEBUG_UART_CRLF_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
`ifdef DEBUG_UART_CRLF_EN
      pend_q   <= pend_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[idx_q];
      default: tx = 1'b1;
    endcase
    tx_active    = (state_q != IDLE);
    dbg.busy     = (count_q == DEPTH_C);
    dbg.overflow = ovf_q;
  end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx at CLK_DIV=4, FIFO_DEPTH=4; line state is logged every cycle and checked afterwards.
module tb_debug_uart_tx;
  logic clk = 1'b0;
  logic res_n;
  logic tx;
  logic tx_active;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   base    = 0;
  int   exp_act;

  logic tx_log   [4096];
  logic act_log  [4096];
  logic busy_log [4096];
  logic ovf_log  [4096];

  debug_uart_tx_if dbg_if ();

  debug_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .dbg       (dbg_if),
    .tx        (tx),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Index k holds the value seen after the k-th rising edge.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      tx_log[cyc]   <= tx;
      act_log[cyc]  <= tx_active;
      busy_log[cyc] <= dbg_if.busy;
      ovf_log[cyc]  <= dbg_if.overflow;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int at(input int k);
    return base + 1 + k;
  endfunction

  task automatic chk_frame(input string tag, input int s, input logic [7:0] b);
    for (int j = 0; j < 10; j++) begin
      logic       e;
      logic [3:0] g;
      e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      for (int k = 0; k < 4; k++) g[k] = tx_log[s + j*4 + k];
      chk($sformatf("%s bit%0d", tag, j), {28'd0, g}, {28'd0, {4{e}}});
    end
  endtask

  task automatic chk_idle(input string tag, input int s, input int n);
    int zeros = 0;
    int acts  = 0;
    for (int i = s; i < s + n; i++) begin
      if (tx_log[i] !== 1'b1) zeros++;
      if (act_log[i] !== 1'b0) acts++;
    end
    chk({tag, " tx low cycles"}, zeros, 0);
    chk({tag, " active cycles"}, acts, 0);
  endtask

  function automatic int cnt_act(input int s, input int n);
    int c = 0;
    for (int i = s; i < s + n; i++) if (act_log[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_n        = 1'b0;
    dbg_if.sig   = 1'b0;
    dbg_if.ascii = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset tx", tx, 1);
    chk("reset busy", dbg_if.busy, 0);
    chk("reset overflow", dbg_if.overflow, 0);
    chk("reset tx_active", tx_active, 0);
    tick();
    res_n = 1'b1;
    tick();

    // single character 0x41
    base = cyc;
    dbg_if.sig = 1'b1; dbg_if.ascii = 8'h41;
    tick();
    dbg_if.sig = 1'b0; dbg_if.ascii = 8'hFF;
    repeat (52) tick();
    chk("single pre tx", tx_log[at(0)], 1);
    chk("single pre active", act_log[at(0)], 0);
    chk_frame("single", at(1), 8'h41);
    chk("single active len", cnt_act(at(0), 50), 40);
    chk("single post tx", tx_log[at(41)], 1);
    chk("single post active", act_log[at(41)], 0);

    // strobe gating: ascii toggles with sig low
    base = cyc;
    for (int i = 0; i < 20; i++) begin
      dbg_if.ascii = 8'($urandom);
      tick();
    end
    repeat (4) tick();
    chk_idle("gating", at(0), 22);
    chk("gating busy", busy_log[at(21)], 0);

    // LF handling
    base = cyc;
    dbg_if.sig = 1'b1; dbg_if.ascii = 8'h0A;
    tick();
    dbg_if.sig = 1'b0;
    repeat (92) tick();
`ifdef DEBUG_UART_CRLF_EN
    chk_frame("crlf cr", at(1), 8'h0D);
    chk_frame("crlf lf", at(41), 8'h0A);
    exp_act = 80;
`else
    chk_frame("lf", at(1), 8'h0A);
    exp_act = 40;
`endif
    chk("lf active len", cnt_act(at(0), 90), exp_act);

    // overflow: six strobes into a 4-deep FIFO
    base = cyc;
    for (int i = 0; i < 6; i++) begin
      dbg_if.sig = 1'b1; dbg_if.ascii = 8'h30 + 8'(i);
      tick();
    end
    dbg_if.sig = 1'b0;
    repeat (258) tick();
    chk("ovf busy e3", busy_log[at(3)], 0);
    chk("ovf busy e4", busy_log[at(4)], 1);
    chk("ovf flag e4", ovf_log[at(4)], 0);
    chk("ovf flag e5", ovf_log[at(5)], 1);
    chk("ovf busy e40", busy_log[at(40)], 1);
    chk("ovf busy e41", busy_log[at(41)], 0);
    for (int i = 0; i < 5; i++)
      chk_frame($sformatf("ovf char%0d", i), at(1) + 40*i, 8'h30 + 8'(i));
    chk_idle("ovf tail", at(201), 58);
    chk("ovf sticky", ovf_log[at(258)], 1);

    // reset during DATA of the first byte
    base = cyc;
    for (int i = 0; i < 5; i++) begin
      dbg_if.sig = 1'b1; dbg_if.ascii = 8'h55 + 8'(i*17);
      tick();
    end
    dbg_if.sig = 1'b0;
    repeat (6) tick();
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    repeat (102) tick();
    chk("rst busy before", busy_log[at(4)], 1);
    chk("rst active before", act_log[at(10)], 1);
    chk("rst ovf before", ovf_log[at(10)], 1);
    chk("rst tx after", tx_log[at(11)], 1);
    chk("rst busy after", busy_log[at(11)], 0);
    chk("rst ovf after", ovf_log[at(11)], 0);
    chk_idle("rst quiet", at(11), 100);

    base = cyc;
    dbg_if.sig = 1'b1; dbg_if.ascii = 8'h42;
    tick();
    dbg_if.sig = 1'b0;
    repeat (62) tick();
    chk_frame("post rst", at(1), 8'h42);
    chk_idle("post rst tail", at(41), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
